// File: rtl/rvsteel_gpio_arbiter_if.sv
// rvsteel_gpio_arbiter_if: GPIO register-port bus bundle shared by requesters and the peripheral
interface rvsteel_gpio_arbiter_if #(
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] rw_address;
  logic [31:0] write_data;
  logic [3:0] write_strobe;
  logic read_request;
  logic write_request;
  logic [31:0] read_data;
  logic read_response;
  logic write_response;
  modport master (
    output rw_address, write_data, write_strobe, read_request, write_request,
    input read_data, read_response, write_response
  );
  modport slave (
    input rw_address, write_data, write_strobe, read_request, write_request,
    output read_data, read_response, write_response
  );
endinterface

// File: rtl/rvsteel_gpio_arbiter.sv
// rvsteel_gpio_arbiter: round-robin arbiter sharing one GPIO port between two masters, with response timeout
module rvsteel_gpio_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic clock,
  input logic reset_n,
  rvsteel_gpio_arbiter_if.slave m0,
  rvsteel_gpio_arbiter_if.slave m1,
  rvsteel_gpio_arbiter_if.master s,
  output logic timeout_error
);
  localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_next;
  logic last_grant, last_grant_next;
  logic grant, grant_next;
  logic op_read, op_read_next;
  logic [7:0] count, count_next;
  logic [ADDR_WIDTH-1:0] address, address_next;
  logic [31:0] write_data, write_data_next;
  logic [3:0] strobe, strobe_next;
  logic [31:0] read_data, read_data_next;
  logic read_request, read_request_next;
  logic write_request, write_request_next;
  logic [1:0] read_response, read_response_next;
  logic [1:0] write_response, write_response_next;
  logic timeout, timeout_next;
  logic req0, req1, pick, done;
  assign req0 = m0.read_request | m0.write_request;
  assign req1 = m1.read_request | m1.write_request;
  assign pick = (req0 & req1) ? ~last_grant : req1;
  assign done = op_read ? s.read_response : s.write_response;
  assign s.rw_address = address;
  assign s.write_data = write_data;
  assign s.write_strobe = strobe;
  assign s.read_request = read_request;
  assign s.write_request = write_request;
  assign m0.read_data = read_data;
  assign m1.read_data = read_data;
  assign m0.read_response = read_response[0];
  assign m1.read_response = read_response[1];
  assign m0.write_response = write_response[0];
  assign m1.write_response = write_response[1];
  assign timeout_error = timeout;
  // Next state and next value of every registered output; pulses default low.
  always_comb begin
    state_next = state;
    last_grant_next = last_grant;
    grant_next = grant;
    op_read_next = op_read;
    count_next = count;
    address_next = address;
    write_data_next = write_data;
    strobe_next = strobe;
    read_data_next = read_data;
    read_request_next = 1'b0;
    write_request_next = 1'b0;
    read_response_next = 2'b00;
    write_response_next = 2'b00;
    timeout_next = 1'b0;
    unique case (state)
      IDLE: if (req0 | req1) begin
        state_next = ISSUE;
        grant_next = pick;
        last_grant_next = (req0 & req1) ? pick : last_grant;
        address_next = pick ? m1.rw_address : m0.rw_address;
        write_data_next = pick ? m1.write_data : m0.write_data;
        strobe_next = pick ? m1.write_strobe : m0.write_strobe;
        op_read_next = pick ? m1.read_request : m0.read_request;
        read_request_next = op_read_next;
        write_request_next = ~op_read_next;
      end
      ISSUE: begin
        state_next = WAIT;
        count_next = 8'd0;
      end
      WAIT: if (done || count == LIMIT) begin
        state_next = RESP;
        read_data_next = done ? (op_read ? s.read_data : read_data) : 32'd0;
        timeout_next = ~done;
        read_response_next[grant] = op_read;
        write_response_next[grant] = ~op_read;
      end else begin
        count_next = count + 8'd1;
      end
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end
  // FSM state, grant history and timeout counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      last_grant <= 1'b1;
      grant <= 1'b0;
      op_read <= 1'b0;
      count <= 8'd0;
    end else begin
      state <= state_next;
      last_grant <= last_grant_next;
      grant <= grant_next;
      op_read <= op_read_next;
      count <= count_next;
    end
  end
  // Registered bus outputs toward GPIO and back to the masters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      address <= '0;
      write_data <= 32'd0;
      strobe <= 4'd0;
      read_data <= 32'd0;
      read_request <= 1'b0;
      write_request <= 1'b0;
      read_response <= 2'b00;
      write_response <= 2'b00;
      timeout <= 1'b0;
    end else begin
      address <= address_next;
      write_data <= write_data_next;
      strobe <= strobe_next;
      read_data <= read_data_next;
      read_request <= read_request_next;
      write_request <= write_request_next;
      read_response <= read_response_next;
      write_response <= write_response_next;
      timeout <= timeout_next;
    end
  end
endmodule

// File: tb/tb_rvsteel_gpio_arbiter.sv
// tb_rvsteel_gpio_arbiter: directed vector bench for the GPIO round-robin arbiter
module tb_rvsteel_gpio_arbiter;
  localparam int TMO = 16;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic timeout_error;
  logic gpio_en = 1'b1;
  logic [31:0] gpio_data = 32'd0;
  logic gr = 1'b0;
  logic gw = 1'b0;
  int checks = 0;
  int errors = 0;
  rvsteel_gpio_arbiter_if #(.ADDR_WIDTH(5)) m0_if ();
  rvsteel_gpio_arbiter_if #(.ADDR_WIDTH(5)) m1_if ();
  rvsteel_gpio_arbiter_if #(.ADDR_WIDTH(5)) s_if ();
  rvsteel_gpio_arbiter #(.ADDR_WIDTH(5), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .m0(m0_if),
    .m1(m1_if),
    .s(s_if),
    .timeout_error(timeout_error)
  );
  always #5 clock = ~clock;
  assign s_if.read_response = gr;
  assign s_if.write_response = gw;
  assign s_if.read_data = gpio_data;
  // GPIO model: answers a request pulse with a one-cycle response in the following cycle.
  always @(posedge clock) begin
    logic r, w;
    r = s_if.read_request;
    w = s_if.write_request;
    #1;
    gr = gpio_en & r;
    gw = gpio_en & w;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  typedef struct {
    logic r0, w0; logic [4:0] a0; logic [31:0] d0; logic [3:0] s0;
    logic r1, w1; logic [4:0] a1; logic [31:0] d1; logic [3:0] s1;
    logic [31:0] gdata; logic gen; logic first;
  } vec_t;
  function automatic vec_t mk(logic r0, logic w0, logic [4:0] a0, logic [31:0] d0, logic [3:0] s0,
                              logic r1, logic w1, logic [4:0] a1, logic [31:0] d1, logic [3:0] s1,
                              logic [31:0] gdata, logic gen, logic first);
    vec_t x;
    x.r0 = r0; x.w0 = w0; x.a0 = a0; x.d0 = d0; x.s0 = s0;
    x.r1 = r1; x.w1 = w1; x.a1 = a1; x.d1 = d1; x.s1 = s1;
    x.gdata = gdata; x.gen = gen; x.first = first;
    return x;
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic quiet(input string name);
    check(name, {27'd0, m0_if.read_response, m0_if.write_response, m1_if.read_response,
                 m1_if.write_response, timeout_error}, 32'd0);
  endtask
  // Called in cycle N with master m's request applied; follows the access to its completion.
  task automatic serve(input logic m, input logic rd, input logic [4:0] a, input logic [31:0] d,
                       input logic [3:0] st, input logic [31:0] exp_rdata, input logic tmo);
    int k;
    logic seen;
    @(posedge clock);
    @(negedge clock);
    check("s_read_request", s_if.read_request, rd);
    check("s_write_request", s_if.write_request, !rd);
    check("s_rw_address", s_if.rw_address, a);
    check("s_write_data", s_if.write_data, d);
    check("s_write_strobe", s_if.write_strobe, st);
    k = 0;
    seen = 1'b0;
    while (!seen && k < TMO + 6) begin
      @(negedge clock);
      k++;
      seen = m0_if.read_response | m0_if.write_response | m1_if.read_response |
             m1_if.write_response | timeout_error;
    end
    check("latency", k, tmo ? TMO + 1 : 2);
    check("resp_read", m ? m1_if.read_response : m0_if.read_response, rd);
    check("resp_write", m ? m1_if.write_response : m0_if.write_response, !rd);
    check("other_resp", m ? (m0_if.read_response | m0_if.write_response)
                          : (m1_if.read_response | m1_if.write_response), 1'b0);
    check("timeout_error", timeout_error, tmo);
    if (rd) check("read_data", m ? m1_if.read_data : m0_if.read_data, exp_rdata);
    @(posedge clock);
    #1;
    if (m) begin
      m1_if.read_request = 1'b0;
      m1_if.write_request = 1'b0;
    end else begin
      m0_if.read_request = 1'b0;
      m0_if.write_request = 1'b0;
    end
    @(negedge clock);
    quiet("resp_pulse");
  endtask
  vec_t vecs[10];
  initial begin
    vecs[0] = mk(1, 0, 5'h00, 32'h0, 4'h0, 1, 0, 5'h04, 32'h0, 4'h0, 32'h000000A1, 1, 0);
    vecs[1] = mk(1, 0, 5'h00, 32'h0, 4'h0, 1, 0, 5'h04, 32'h0, 4'h0, 32'h000000B2, 1, 1);
    vecs[2] = mk(0, 1, 5'h08, 32'h5, 4'hF, 0, 0, 5'h00, 32'h0, 4'h0, 32'h00000000, 1, 0);
    vecs[3] = mk(0, 0, 5'h00, 32'h0, 4'h0, 1, 0, 5'h03, 32'h0, 4'h0, 32'h000000A5, 1, 1);
    vecs[4] = mk(1, 1, 5'h1F, 32'h77, 4'h3, 0, 0, 5'h00, 32'h0, 4'h0, 32'h12345678, 1, 0);
    vecs[5] = mk(0, 1, 5'h02, 32'h11, 4'h1, 0, 1, 5'h07, 32'h22, 4'h2, 32'h00000000, 1, 0);
    vecs[6] = mk(1, 0, 5'h09, 32'h0, 4'h0, 0, 1, 5'h0B, 32'hCAFE, 4'hC, 32'h00000009, 1, 1);
    vecs[7] = mk(0, 0, 5'h00, 32'h0, 4'h0, 0, 1, 5'h10, 32'h1, 4'h8, 32'h00000000, 0, 1);
    vecs[8] = mk(1, 0, 5'h11, 32'h0, 4'h0, 0, 0, 5'h00, 32'h0, 4'h0, 32'h00000055, 0, 0);
    vecs[9] = mk(0, 0, 5'h00, 32'h0, 4'h0, 1, 0, 5'h12, 32'h0, 4'h0, 32'hDEADBEEF, 1, 1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clock);
      #1;
      m0_if.rw_address = 5'($urandom);
      m0_if.write_data = $urandom;
      m0_if.write_strobe = 4'($urandom);
      m0_if.read_request = 1'($urandom);
      m0_if.write_request = 1'($urandom);
      m1_if.rw_address = 5'($urandom);
      m1_if.write_data = $urandom;
      m1_if.write_strobe = 4'($urandom);
      m1_if.read_request = 1'($urandom);
      m1_if.write_request = 1'($urandom);
      gpio_data = $urandom;
      @(negedge clock);
      quiet("reset_resp");
      check("reset_s_req", {s_if.read_request, s_if.write_request}, 2'b00);
    end
    m0_if.read_request = 1'b0;
    m0_if.write_request = 1'b0;
    m1_if.read_request = 1'b0;
    m1_if.write_request = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      vec_t v;
      v = vecs[i];
      @(posedge clock);
      #1;
      m0_if.read_request = v.r0; m0_if.write_request = v.w0; m0_if.rw_address = v.a0;
      m0_if.write_data = v.d0; m0_if.write_strobe = v.s0;
      m1_if.read_request = v.r1; m1_if.write_request = v.w1; m1_if.rw_address = v.a1;
      m1_if.write_data = v.d1; m1_if.write_strobe = v.s1;
      gpio_en = v.gen;
      gpio_data = v.gdata;
      if (v.first)
        serve(1'b1, v.r1, v.a1, v.d1, v.s1, v.gen ? v.gdata : 32'd0, !v.gen);
      else
        serve(1'b0, v.r0, v.a0, v.d0, v.s0, v.gen ? v.gdata : 32'd0, !v.gen);
      if ((v.r0 | v.w0) && (v.r1 | v.w1)) begin
        if (v.first)
          serve(1'b0, v.r0, v.a0, v.d0, v.s0, v.gen ? v.gdata : 32'd0, !v.gen);
        else
          serve(1'b1, v.r1, v.a1, v.d1, v.s1, v.gen ? v.gdata : 32'd0, !v.gen);
      end
    end
    @(posedge clock);
    #1;
    gpio_en = 1'b0;
    m0_if.read_request = 1'b1;
    m0_if.rw_address = 5'h0A;
    @(posedge clock);
    @(posedge clock);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    quiet("abort_resp");
    check("abort_s_req", {s_if.read_request, s_if.write_request}, 2'b00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      quiet("abort_hold");
    end
    m0_if.read_request = 1'b0;
    gpio_en = 1'b1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      quiet("post_abort_idle");
    end
    @(posedge clock);
    #1;
    m0_if.read_request = 1'b1; m0_if.rw_address = 5'h01; m0_if.write_data = 32'h0; m0_if.write_strobe = 4'h0;
    m1_if.read_request = 1'b1; m1_if.rw_address = 5'h02; m1_if.write_data = 32'h0; m1_if.write_strobe = 4'h0;
    gpio_data = 32'h0000_0077;
    serve(1'b0, 1'b1, 5'h01, 32'h0, 4'h0, 32'h0000_0077, 1'b0);
    serve(1'b1, 1'b1, 5'h02, 32'h0, 4'h0, 32'h0000_0077, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
